// File: rtl/fft_out_serializer.sv
// Streams one captured 32-point FFT frame out one point per cycle, converting
// each Q-format component to a rounded, saturated integer; optional bit-reverse.

module fft_os_cvt #(
  parameter int bits    = 16,
  parameter int fix_bit = 7,
  parameter int OUT_W   = 9
) (
  input  logic [bits-1:0]  i_v,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_v,
  output logic             o_sat
);
  localparam int EW = bits + 1;
  localparam logic signed [EW-1:0] RND  = EW'(1) << (fix_bit - 1);
  localparam logic signed [EW-1:0] MAXV = EW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  logic signed [EW-1:0] w_ext, w_t;
  logic                 w_hi, w_lo;

  // One guard bit keeps the rounding add from wrapping at the positive edge.
  assign w_ext = $signed({i_v[bits-1], i_v}) + RND;
  assign w_t   = w_ext >>> fix_bit;
  assign w_hi  = w_t > MAXV;
  assign w_lo  = w_t < MINV;

  always_comb begin
    o_v   = '0;
    o_sat = 1'b0;
    if (i_en) begin
      o_sat = w_hi | w_lo;
      if (w_hi)      o_v = MAXV[OUT_W-1:0];
      else if (w_lo) o_v = MINV[OUT_W-1:0];
      else           o_v = w_t[OUT_W-1:0];
    end
  end
endmodule

module fft_out_serializer #(
  parameter int N_PTS   = 32,
  parameter int bits    = 16,
  parameter int fix_bit = 7,
  parameter int OUT_W   = 9,
  parameter int BITREV  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PTS*2*bits-1:0]    in_flat,
  input  logic                       load_valid,
  output logic                       load_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_re,
  output logic [OUT_W-1:0]           out_im,
  output logic [$clog2(N_PTS)-1:0]   out_idx,
  output logic                       out_last,
  output logic                       out_sat
);
  localparam int LW = $clog2(N_PTS);
  localparam logic [LW-1:0] LAST = LW'(N_PTS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 r_state, w_next;
  logic [LW-1:0]          r_k, w_sel;
  logic [2*bits-1:0]      r_buf [N_PTS];
  logic [2*bits-1:0]      w_word;
  logic                   w_load, w_xfer, w_valid;
  logic [1:0][OUT_W-1:0]  w_cv;
  logic [1:0]             w_cs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_load  = 1'b0;
    w_xfer  = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = load_valid;
        if (load_valid) w_next = STREAM;
      end
      STREAM: begin
        w_valid = 1'b1;
        w_xfer  = out_ready;
        if (out_ready && r_k == LAST) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_k <= '0;
    else if (w_load) r_k <= '0;
    else if (w_xfer) r_k <= (r_k == LAST) ? '0 : r_k + LW'(1);
  end

  // Frame buffer carries no reset: its contents are never visible outside STREAM.
  always_ff @(posedge clk) begin
    if (w_load)
      for (int i = 0; i < N_PTS; i++) r_buf[i] <= in_flat[i*2*bits +: 2*bits];
  end

  genvar b;
  generate
    for (b = 0; b < LW; b++) begin : g_sel
      if (BITREV != 0) begin : g_rev
        assign w_sel[b] = r_k[LW-1-b];
      end else begin : g_nat
        assign w_sel[b] = r_k[b];
      end
    end
  endgenerate

  assign w_word = r_buf[w_sel];

  genvar c;
  generate
    for (c = 0; c < 2; c++) begin : g_cvt
      fft_os_cvt #(.bits(bits), .fix_bit(fix_bit), .OUT_W(OUT_W)) u_cvt (
        .i_v   (w_word[c*bits +: bits]),
        .i_en  (w_valid),
        .o_v   (w_cv[c]),
        .o_sat (w_cs[c])
      );
    end
  endgenerate

  assign load_ready = (r_state == IDLE);
  assign out_valid  = w_valid;
  assign out_re     = w_cv[0];
  assign out_im     = w_cv[1];
  assign out_sat    = |w_cs;
  assign out_idx    = r_k;
  assign out_last   = w_valid && (r_k == LAST);
endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: natural and bit-reversed instances
// share stimulus; conversion vectors come from a table, sequences cover handshake corners.

module tb_fft_out_serializer;
  localparam int N = 32;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_flat = '0;
  logic           load_valid = 1'b0;
  logic           out_ready = 1'b0;

  logic       o0_lrdy, o0_valid, o0_last, o0_sat;
  logic [8:0] o0_re, o0_im;
  logic [4:0] o0_idx;
  logic       o1_lrdy, o1_valid, o1_last, o1_sat;
  logic [8:0] o1_re, o1_im;
  logic [4:0] o1_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fft_out_serializer #(.BITREV(0)) u_nat (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .load_valid(load_valid),
    .load_ready(o0_lrdy), .out_valid(o0_valid), .out_ready(out_ready),
    .out_re(o0_re), .out_im(o0_im), .out_idx(o0_idx), .out_last(o0_last), .out_sat(o0_sat));

  fft_out_serializer #(.BITREV(1)) u_rev (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .load_valid(load_valid),
    .load_ready(o1_lrdy), .out_valid(o1_valid), .out_ready(out_ready),
    .out_re(o1_re), .out_im(o1_im), .out_idx(o1_idx), .out_last(o1_last), .out_sat(o1_sat));

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    int          exp_re;
    int          exp_im;
    int          exp_sat;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int s9(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  function automatic int br5(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) r |= ((k >> b) & 1) << (4 - b);
    return r;
  endfunction

  task automatic ramp_frame();
    for (int i = 0; i < N; i++) in_flat[i*W +: W] = {16'h0000, 16'(i << 7)};
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!o0_valid) break;
      step();
    end
    chk("drain_done", int'(o0_valid), 0);
  endtask

  vec_t tbl [10];

  initial begin
    int cnt;
    int s_valid, s_idx, s_re, s_last;
    logic r;

    tbl[0] = '{16'h0040, 16'h0000,    1,    0, 0};
    tbl[1] = '{16'h003F, 16'h0000,    0,    0, 0};
    tbl[2] = '{16'hFFBF, 16'h0000,   -1,    0, 0};
    tbl[3] = '{16'hFFC0, 16'h0000,    0,    0, 0};
    tbl[4] = '{16'h6400, 16'h0000,  200,    0, 0};
    tbl[5] = '{16'h7FFF, 16'h8000,  255, -256, 1};
    tbl[6] = '{16'h7F80, 16'h0000,  255,    0, 0};
    tbl[7] = '{16'h0000, 16'hFFBF,    0,   -1, 0};
    tbl[8] = '{16'h8000, 16'h7FFF, -256,  255, 1};
    tbl[9] = '{16'h8000, 16'h0000, -256,    0, 0};

    // Reset state
    #3;
    chk("rst_load_ready", int'(o0_lrdy), 1);
    chk("rst_out_valid", int'(o0_valid), 0);
    chk("rst_out_re", s9(o0_re), 0);
    chk("rst_out_im", s9(o0_im), 0);
    chk("rst_out_idx", int'(o0_idx), 0);
    chk("rst_out_last", int'(o0_last), 0);
    chk("rst_out_sat", int'(o0_sat), 0);
    #5 rst_n = 1'b1;
    step();

    // Full drain, natural and bit-reversed; load_valid on the final beat is refused
    ramp_frame();
    load_valid = 1'b1;
    out_ready  = 1'b1;
    step();
    load_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("nat_valid[%0d]", k), int'(o0_valid), 1);
      chk($sformatf("nat_lrdy[%0d]", k), int'(o0_lrdy), 0);
      chk($sformatf("nat_idx[%0d]", k), int'(o0_idx), k);
      chk($sformatf("nat_re[%0d]", k), s9(o0_re), k);
      chk($sformatf("nat_im[%0d]", k), s9(o0_im), 0);
      chk($sformatf("nat_last[%0d]", k), int'(o0_last), (k == N - 1) ? 1 : 0);
      chk($sformatf("rev_idx[%0d]", k), int'(o1_idx), k);
      chk($sformatf("rev_re[%0d]", k), s9(o1_re), br5(k));
      chk($sformatf("rev_last[%0d]", k), int'(o1_last), (k == N - 1) ? 1 : 0);
      if (k == 1) chk("rev_re_k1", s9(o1_re), 16);
      if (k == 3) chk("rev_re_k3", s9(o1_re), 24);
      if (k == N - 1) load_valid = 1'b1;
      step();
    end
    chk("idle_gap_lrdy", int'(o0_lrdy), 1);
    chk("idle_gap_valid", int'(o0_valid), 0);
    chk("idle_gap_rev_valid", int'(o1_valid), 0);
    step();
    load_valid = 1'b0;
    chk("late_capture_valid", int'(o0_valid), 1);
    chk("late_capture_idx", int'(o0_idx), 0);
    drain();

    // Conversion table: vector j in slot j, read back on natural beat j
    in_flat = '0;
    foreach (tbl[j]) in_flat[j*W +: W] = {tbl[j].im, tbl[j].re};
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    foreach (tbl[j]) begin
      chk($sformatf("cvt_re[%0d]", j), s9(o0_re), tbl[j].exp_re);
      chk($sformatf("cvt_im[%0d]", j), s9(o0_im), tbl[j].exp_im);
      chk($sformatf("cvt_sat[%0d]", j), int'(o0_sat), tbl[j].exp_sat);
      step();
    end
    drain();

    // Backpressure with load_valid held high and the input frame changed after capture
    ramp_frame();
    load_valid = 1'b1;
    step();
    for (int i = 0; i < N; i++) in_flat[i*W +: W] = 32'h7FFF_7FFF;
    cnt = 0;
    for (int cyc = 0; cyc < 400 && cnt < N; cyc++) begin
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      s_valid = int'(o0_valid);
      s_idx   = int'(o0_idx);
      s_re    = s9(o0_re);
      s_last  = int'(o0_last);
      chk("bp_lrdy_low", int'(o0_lrdy), 0);
      step();
      if (s_valid == 1 && !r) begin
        chk("bp_hold_valid", int'(o0_valid), 1);
        chk("bp_hold_idx", int'(o0_idx), s_idx);
        chk("bp_hold_re", s9(o0_re), s_re);
      end else if (s_valid == 1) begin
        chk($sformatf("bp_idx[%0d]", cnt), s_idx, cnt);
        chk($sformatf("bp_re[%0d]", cnt), s_re, cnt);
        chk($sformatf("bp_last[%0d]", cnt), s_last, (cnt == N - 1) ? 1 : 0);
        cnt++;
      end
    end
    chk("bp_beats", cnt, N);
    chk("bp_idle_lrdy", int'(o0_lrdy), 1);
    chk("bp_idle_valid", int'(o0_valid), 0);
    step();
    load_valid = 1'b0;
    chk("bp_recapture", int'(o0_valid), 1);

    // Reset mid-frame at k = 10
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (o0_idx == 5'd10) break;
      step();
    end
    chk("mid_idx_reached", int'(o0_idx), 10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(o0_valid), 0);
    chk("mid_rst_rev_valid", int'(o1_valid), 0);
    chk("mid_rst_lrdy", int'(o0_lrdy), 1);
    chk("mid_rst_idx", int'(o0_idx), 0);
    chk("mid_rst_re", s9(o0_re), 0);
    step();
    rst_n = 1'b1;
    ramp_frame();
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("post_rst_valid", int'(o0_valid), 1);
    chk("post_rst_idx", int'(o0_idx), 0);
    chk("post_rst_re", s9(o0_re), 0);
    step();
    chk("post_rst_idx1", int'(o0_idx), 1);
    chk("post_rst_re1", s9(o0_re), 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
